voice_allocator: RTL and testbench

Polyphonic voice allocator sitting between the note-event source (MIDI decoder or sequencer) and a bank of `NUM_VOICES` ADSR envelope generators. It accepts note-on/note-off events over a valid/ready handshake and maps each note to a voice. It drives each voice's Gate, and retriggers or steals voices so every new note produces a clean rising Gate edge at its envelope.

---
 rtl/synth_pkg.sv | 21 ++
 rtl/voice_allocator_if.sv | 12 +
 rtl/voice_select.sv | 34 +++
 rtl/voice_allocator.sv | 166 ++++++++++++++++
 tb/tb_voice_allocator.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice-allocation slice.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECIDE = 2'b01,
        RETRIG = 2'b10
    } alloc_state_e;

    typedef enum logic {
        SEL_LOWEST = 1'b0,
        SEL_OLDEST = 1'b1
    } sel_mode_e;

    localparam int unsigned NOTE_WIDTH_DEFAULT = 7;

    function automatic int unsigned rank_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the event source and the voice allocator.
interface voice_allocator_if #(
    parameter int unsigned NOTE_WIDTH = synth_pkg::NOTE_WIDTH_DEFAULT
);
    logic                  NoteValid;
    logic                  NoteReady;
    logic                  NoteOn;
    logic [NOTE_WIDTH-1:0] NoteNum;

    modport master (output NoteValid, output NoteOn, output NoteNum, input NoteReady);
    modport slave  (input NoteValid, input NoteOn, input NoteNum, output NoteReady);
endinterface

// File: rtl/voice_select.sv
// Picks one voice from a candidate mask: lowest index, or oldest (largest rank).
module voice_select
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic [NUM_VOICES-1:0]                         cand_i,
    input  logic [NUM_VOICES*rank_width(NUM_VOICES)-1:0]  rank_i,
    input  sel_mode_e                                     mode_i,
    output logic [rank_width(NUM_VOICES)-1:0]             idx_o,
    output logic                                          found_o
);
    localparam int unsigned RW = rank_width(NUM_VOICES);

    logic [RW-1:0] r;
    logic [RW-1:0] best;

    // In lowest mode only the first candidate is taken; in oldest mode a higher rank replaces it.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        best    = '0;
        r       = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            r = rank_i[v*RW +: RW];
            if (cand_i[v] && (!found_o || (mode_i == SEL_OLDEST && r > best))) begin
                idx_o   = RW'(v);
                best    = r;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto ADSR voices with retrigger and stealing.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_WIDTH = NOTE_WIDTH_DEFAULT
) (
    input  logic                             Clock,
    input  logic                             Reset,
    voice_allocator_if.slave                 ev,
    input  logic [NUM_VOICES-1:0]            Running,
    output logic [NUM_VOICES-1:0]            Gate,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] VoiceNote,
    output logic                             Steal
);
    localparam int unsigned NV = NUM_VOICES;
    localparam int unsigned NW = NOTE_WIDTH;
    localparam int unsigned RW = rank_width(NUM_VOICES);

    alloc_state_e  state_q;
    logic          ready_q;
    logic          steal_q;
    logic          on_q;
    logic [NW-1:0] num_q;
    logic [RW-1:0] tgt_q;
    logic [NV-1:0] gate_q;
    logic [NW-1:0] note_q [NV];
    logic [RW-1:0] rank_q [NV];
    logic [RW-1:0] rank_d [NV];

    logic [NV-1:0]    match_mask, free_mask, rel_mask;
    logic [NV*RW-1:0] rank_flat;
    logic [RW-1:0]    match_idx, free_idx, rel_idx, gated_idx;
    logic             match_found, free_found, rel_found, gated_found;

    logic [RW-1:0] tgt_d;
    logic          hit_d, retrig_d, steal_d;

    // Voice classification against the latched event; Running only matters in DECIDE.
    always_comb begin
        match_mask = '0;
        free_mask  = '0;
        rel_mask   = '0;
        rank_flat  = '0;
        for (int v = 0; v < NV; v++) begin
            match_mask[v]          = gate_q[v] && (note_q[v] == num_q);
            free_mask[v]           = !gate_q[v] && !Running[v];
            rel_mask[v]            = !gate_q[v] && Running[v];
            rank_flat[v*RW +: RW]  = rank_q[v];
        end
    end

    voice_select #(.NUM_VOICES(NV)) u_match (
        .cand_i(match_mask), .rank_i(rank_flat), .mode_i(SEL_LOWEST),
        .idx_o(match_idx), .found_o(match_found)
    );
    voice_select #(.NUM_VOICES(NV)) u_free (
        .cand_i(free_mask), .rank_i(rank_flat), .mode_i(SEL_LOWEST),
        .idx_o(free_idx), .found_o(free_found)
    );
    voice_select #(.NUM_VOICES(NV)) u_rel (
        .cand_i(rel_mask), .rank_i(rank_flat), .mode_i(SEL_OLDEST),
        .idx_o(rel_idx), .found_o(rel_found)
    );
    voice_select #(.NUM_VOICES(NV)) u_gated (
        .cand_i(gate_q), .rank_i(rank_flat), .mode_i(SEL_OLDEST),
        .idx_o(gated_idx), .found_o(gated_found)
    );

    // Rule priority: retrigger same note, free voice, oldest releasing, steal oldest gated.
    always_comb begin
        tgt_d    = '0;
        hit_d    = 1'b0;
        retrig_d = 1'b0;
        steal_d  = 1'b0;
        if (on_q) begin
            if (match_found) begin
                tgt_d = match_idx; hit_d = 1'b1; retrig_d = 1'b1;
            end else if (free_found) begin
                tgt_d = free_idx;  hit_d = 1'b1;
            end else if (rel_found) begin
                tgt_d = rel_idx;   hit_d = 1'b1;
            end else if (gated_found) begin
                tgt_d = gated_idx; hit_d = 1'b1; retrig_d = 1'b1; steal_d = 1'b1;
            end
        end else if (match_found) begin
            tgt_d = match_idx; hit_d = 1'b1;
        end
    end

    // Target becomes newest; everything younger than its old rank ages by one.
    always_comb begin
        for (int v = 0; v < NV; v++) begin
            rank_d[v] = rank_q[v];
            if (RW'(v) == tgt_d) begin
                rank_d[v] = '0;
            end else if (rank_q[v] < rank_q[tgt_d]) begin
                rank_d[v] = rank_q[v] + RW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            steal_q <= 1'b0;
            on_q    <= 1'b0;
            num_q   <= '0;
            tgt_q   <= '0;
            gate_q  <= '0;
            for (int v = 0; v < NV; v++) begin
                note_q[v] <= '0;
                rank_q[v] <= RW'(v);
            end
        end else begin
            steal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev.NoteValid && ready_q) begin
                        on_q    <= ev.NoteOn;
                        num_q   <= ev.NoteNum;
                        state_q <= DECIDE;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                DECIDE: begin
                    tgt_q <= tgt_d;
                    if (hit_d && on_q) begin
                        rank_q        <= rank_d;
                        note_q[tgt_d] <= num_q;
                        gate_q[tgt_d] <= !retrig_d;
                        steal_q       <= steal_d;
                    end else if (hit_d) begin
                        gate_q[tgt_d] <= 1'b0;
                    end
                    state_q <= retrig_d ? RETRIG : IDLE;
                    ready_q <= !retrig_d;
                end
                RETRIG: begin
                    gate_q[tgt_q] <= 1'b1;
                    state_q       <= IDLE;
                    ready_q       <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        VoiceNote = '0;
        for (int v = 0; v < NV; v++) begin
            VoiceNote[v*NW +: NW] = note_q[v];
        end
    end

    assign Gate         = gate_q;
    assign Steal        = steal_q;
    assign ev.NoteReady = ready_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with an age-queue reference model checked every cycle.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int NW = 7;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [NV-1:0]     running;
    logic [NV-1:0]     gate;
    logic [NV*NW-1:0]  vnote;
    logic              steal;

    voice_allocator_if #(.NOTE_WIDTH(NW)) ev();

    voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW)) dut (
        .Clock(Clock), .Reset(Reset), .ev(ev), .Running(running),
        .Gate(gate), .VoiceNote(vnote), .Steal(steal)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;
    int steal_seen = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: voice ages kept as a newest-first list of voice indices.
    int            order[$];
    bit            m_gate [NV];
    logic [NW-1:0] m_note [NV];
    bit            m_ready, m_steal, m_on;
    logic [NW-1:0] m_num;
    int            m_phase;
    int            m_tgt;

    function automatic void touch(input int v);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == v) begin
                order.delete(i);
                break;
            end
        end
        order.push_front(v);
    endfunction

    function automatic int oldest_of(input logic [NV-1:0] cand);
        for (int i = order.size() - 1; i >= 0; i--)
            if (cand[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic void model_decide();
        int t;
        logic [NV-1:0] rel, gt;
        t = -1;
        for (int v = 0; v < NV; v++)
            if (t < 0 && m_gate[v] && m_note[v] == m_num) t = v;
        m_phase = 0;
        m_ready = 1'b1;
        if (!m_on) begin
            if (t >= 0) m_gate[t] = 1'b0;
            return;
        end
        if (t >= 0) begin
            m_gate[t] = 1'b0; touch(t); m_tgt = t; m_phase = 2; m_ready = 1'b0;
            return;
        end
        for (int v = 0; v < NV; v++)
            if (t < 0 && !m_gate[v] && !running[v]) t = v;
        for (int v = 0; v < NV; v++) begin
            rel[v] = !m_gate[v] && running[v];
            gt[v]  = m_gate[v];
        end
        if (t < 0) t = oldest_of(rel);
        if (t >= 0) begin
            m_gate[t] = 1'b1; m_note[t] = m_num; touch(t);
            return;
        end
        t = oldest_of(gt);
        m_gate[t] = 1'b0; m_note[t] = m_num; m_steal = 1'b1; touch(t);
        m_tgt = t; m_phase = 2; m_ready = 1'b0;
    endfunction

    always @(posedge Clock) begin
        if (!Reset) begin
            order.delete();
            for (int v = 0; v < NV; v++) begin
                m_gate[v] = 1'b0; m_note[v] = '0; order.push_back(v);
            end
            m_ready = 1'b0; m_steal = 1'b0; m_phase = 0; m_on = 1'b0; m_num = '0; m_tgt = 0;
        end else begin
            m_steal = 1'b0;
            if (m_phase == 1) begin
                model_decide();
            end else if (m_phase == 2) begin
                m_gate[m_tgt] = 1'b1; m_phase = 0; m_ready = 1'b1;
            end else if (ev.NoteValid && m_ready) begin
                m_on = ev.NoteOn; m_num = ev.NoteNum; m_phase = 1; m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        logic [NV-1:0]    eg;
        logic [NV*NW-1:0] en;
        if (chk_en) begin
            for (int v = 0; v < NV; v++) begin
                eg[v] = m_gate[v];
                en[v*NW +: NW] = m_note[v];
            end
            check("model_gate", gate, eg);
            check("model_voicenote", vnote, en);
            check("model_ready", ev.NoteReady, m_ready);
            check("model_steal", steal, m_steal);
            if (steal) steal_seen++;
        end
    end

    task automatic send(input bit on, input logic [NW-1:0] num);
        int n = 0;
        while (!ev.NoteReady && n < 10) begin
            @(negedge Clock);
            n++;
        end
        check("send_ready", ev.NoteReady, 1'b1);
        ev.NoteValid = 1'b1; ev.NoteOn = on; ev.NoteNum = num;
        @(negedge Clock);
        ev.NoteValid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!ev.NoteReady && n < 10);
        check("settle_ready", ev.NoteReady, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; running = '0;
        ev.NoteValid = 1'b0; ev.NoteOn = 1'b0; ev.NoteNum = '0;
        repeat (3) @(negedge Clock);
        chk_en = 1'b1;
        check("rst_ready", ev.NoteReady, 1'b0);
        check("rst_gate", gate, 4'b0000);
        check("rst_steal", steal, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        check("ready_after_rst", ev.NoteReady, 1'b1);

        send(1, 7'd60); send(1, 7'd62); send(1, 7'd64); send(1, 7'd65);
        settle();
        check("fill_gate", gate, 4'b1111);
        check("fill_notes", vnote, {7'd65, 7'd64, 7'd62, 7'd60});
        check("fill_no_steal", steal_seen, 0);

        running = 4'b1111;
        send(1, 7'd67);
        check("steal_ready_k", ev.NoteReady, 1'b0);
        @(negedge Clock);
        check("steal_gate_low", gate, 4'b1110);
        check("steal_pulse", steal, 1'b1);
        check("steal_ready_k1", ev.NoteReady, 1'b0);
        @(negedge Clock);
        check("steal_gate_high", gate, 4'b1111);
        check("steal_pulse_end", steal, 1'b0);
        check("steal_note", vnote[0 +: NW], 7'd67);
        check("steal_ready_k2", ev.NoteReady, 1'b1);
        check("steal_count1", steal_seen, 1);

        send(0, 7'd62);
        @(negedge Clock);
        check("off62_gate", gate, 4'b1101);
        check("off62_ready", ev.NoteReady, 1'b1);
        send(1, 7'd70);
        settle();
        check("reuse_rel_gate", gate, 4'b1111);
        check("reuse_rel_note", vnote[NW +: NW], 7'd70);

        send(1, 7'd64);
        @(negedge Clock);
        check("retrig_low", gate, 4'b1011);
        check("retrig_no_steal", steal, 1'b0);
        @(negedge Clock);
        check("retrig_high", gate, 4'b1111);
        check("retrig_ready", ev.NoteReady, 1'b1);

        send(0, 7'd50);
        @(negedge Clock);
        check("off50_gate", gate, 4'b1111);
        check("off50_ready", ev.NoteReady, 1'b1);

        send(0, 7'd67); send(0, 7'd65);
        settle();
        check("two_rel_gate", gate, 4'b0110);
        send(1, 7'd72);
        settle();
        check("oldest_rel_gate", gate, 4'b1110);
        check("oldest_rel_note", vnote[3*NW +: NW], 7'd72);
        running = 4'b1110;
        send(1, 7'd74);
        settle();
        check("free_first_gate", gate, 4'b1111);
        check("free_first_note", vnote[0 +: NW], 7'd74);

        running = 4'b1111;
        send(1, 7'd76);
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check("midrst_gate", gate, 4'b0000);
            check("midrst_ready", ev.NoteReady, 1'b0);
            check("midrst_steal", steal, 1'b0);
        end
        Reset = 1'b1;
        @(negedge Clock);
        check("post_rst_ready", ev.NoteReady, 1'b1);
        check("post_rst_gate", gate, 4'b0000);

        running = 4'b0000;
        send(1, 7'd80); send(1, 7'd81); send(1, 7'd82); send(1, 7'd83);
        settle();
        running = 4'b1111;
        send(1, 7'd84);
        @(negedge Clock);
        check("rank_reset_steal_v0", gate, 4'b1110);
        settle();
        check("rank_reset_note", vnote[0 +: NW], 7'd84);
        check("steal_count2", steal_seen, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
